// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the memory-stage controller: FSM encoding and parameter defaults.
package mem_stage_ctrl_pkg;

    localparam int LEN_DEFAULT       = 32;
    localparam int BASE_ADDR_DEFAULT = 1024;
    localparam int TIMEOUT_DEFAULT   = 255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_stage_ctrl_mem_wb_reg.sv
// MEM/WB pipeline register: synchronous clear, loads only when the pipeline is not frozen.
module mem_wb_reg
    import mem_stage_ctrl_pkg::*;
#(
    parameter int len = LEN_DEFAULT
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           ld,
    input  logic           wb_en,
    input  logic           mem_read,
    input  logic [len-1:0] pc,
    input  logic [len-1:0] instruction,
    input  logic [len-1:0] alu_result,
    input  logic [len-1:0] mem_data,
    input  logic [4:0]     dest,
    output logic           wb_en_out,
    output logic           mem_read_out,
    output logic [len-1:0] pc_out,
    output logic [len-1:0] instruction_out,
    output logic [len-1:0] alu_result_out,
    output logic [len-1:0] mem_data_out,
    output logic [4:0]     dest_out
);

    always_ff @(posedge clock) begin
        if (reset) begin
            wb_en_out       <= 1'b0;
            mem_read_out    <= 1'b0;
            pc_out          <= '0;
            instruction_out <= '0;
            alu_result_out  <= '0;
            mem_data_out    <= '0;
            dest_out        <= '0;
        end else if (ld) begin
            wb_en_out       <= wb_en;
            mem_read_out    <= mem_read;
            pc_out          <= pc;
            instruction_out <= instruction;
            alu_result_out  <= alu_result;
            mem_data_out    <= mem_data;
            dest_out        <= dest;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory stage: issues loads/stores over a req/ready handshake, freezes upstream while busy,
// and feeds the MEM/WB register.
//   state  | meaning
//   IDLE   | no access pending; non-memory ops pass straight into MEM/WB
//   ACCESS | request outstanding, waiting for mem_ready or timeout
//   DONE   | access finished; MEM/WB and EXE/MEM advance together
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int len       = LEN_DEFAULT,
    parameter int BASE_ADDR = BASE_ADDR_DEFAULT,
    parameter int TIMEOUT   = TIMEOUT_DEFAULT
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           wb_en,
    input  logic           mem_read,
    input  logic           mem_write,
    input  logic [len-1:0] pc,
    input  logic [len-1:0] instruction,
    input  logic [len-1:0] alu_result,
    input  logic [len-1:0] src2_val,
    input  logic [4:0]     dest,
    output logic           freeze,
    output logic           mem_req,
    output logic           mem_we,
    output logic [len-1:0] mem_addr,
    output logic [len-1:0] mem_wdata,
    input  logic [len-1:0] mem_rdata,
    input  logic           mem_ready,
    output logic           mem_error,
    output logic           wb_en_out,
    output logic           mem_read_out,
    output logic [len-1:0] pc_out,
    output logic [len-1:0] instruction_out,
    output logic [len-1:0] alu_result_out,
    output logic [len-1:0] mem_data_out,
    output logic [4:0]     dest_out
);

    localparam logic [len-1:0] BASE       = len'(BASE_ADDR);
    localparam logic [7:0]     LAST_COUNT = 8'(TIMEOUT - 1);

    state_t         state;
    logic [7:0]     count;
    logic [len-1:0] rdata_hold;
    logic [len-1:0] wb_data;
    logic [len-1:0] byte_offset;
    logic           mem_op;
    logic           timeout_hit;

    assign mem_op      = mem_read | mem_write;
    assign freeze      = (state == ST_IDLE && mem_op && !reset) || (state == ST_ACCESS);
    assign timeout_hit = (count == LAST_COUNT);
    assign byte_offset = alu_result - BASE;
    // Only DONE carries load data into MEM/WB; plain ALU ops write zero.
    assign wb_data     = (state == ST_DONE) ? rdata_hold : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            count      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata_hold <= '0;
            mem_error  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_op) begin
                        mem_req   <= 1'b1;
                        mem_we    <= mem_write;
                        mem_addr  <= byte_offset >> 2;
                        mem_wdata <= src2_val;
                        count     <= '0;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    count <= count + 8'd1;
                    // A ready on the timeout cycle still counts as a normal completion.
                    if (mem_ready) begin
                        rdata_hold <= mem_we ? '0 : mem_rdata;
                        mem_req    <= 1'b0;
                        state      <= ST_DONE;
                    end else if (timeout_hit) begin
                        rdata_hold <= '0;
                        mem_req    <= 1'b0;
                        mem_error  <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    mem_wb_reg #(.len(len)) u_mem_wb_reg (
        .clock           (clock),
        .reset           (reset),
        .ld              (~freeze),
        .wb_en           (wb_en),
        .mem_read        (mem_read),
        .pc              (pc),
        .instruction     (instruction),
        .alu_result      (alu_result),
        .mem_data        (wb_data),
        .dest            (dest),
        .wb_en_out       (wb_en_out),
        .mem_read_out    (mem_read_out),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .alu_result_out  (alu_result_out),
        .mem_data_out    (mem_data_out),
        .dest_out        (dest_out)
    );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl (TIMEOUT=4): scoreboard of expected MEM/WB contents per op.
module tb_mem_stage_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        wb_en, mem_read, mem_write;
    logic [31:0] pc, instruction, alu_result, src2_val;
    logic [4:0]  dest;
    logic        freeze, mem_req, mem_we, mem_error;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;
    logic        wb_en_out, mem_read_out;
    logic [31:0] pc_out, instruction_out, alu_result_out, mem_data_out;
    logic [4:0]  dest_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wb_en;
        logic        mem_read;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] alu;
        logic [31:0] data;
        logic [4:0]  dest;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] pc_ctr   = 32'h100;
    logic [31:0] prev_alu = 32'h0;

    always #5 clock = ~clock;

    mem_stage_ctrl #(.len(32), .BASE_ADDR(1024), .TIMEOUT(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .wb_en           (wb_en),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .pc              (pc),
        .instruction     (instruction),
        .alu_result      (alu_result),
        .src2_val        (src2_val),
        .dest            (dest),
        .freeze          (freeze),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_ready       (mem_ready),
        .mem_error       (mem_error),
        .wb_en_out       (wb_en_out),
        .mem_read_out    (mem_read_out),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .alu_result_out  (alu_result_out),
        .mem_data_out    (mem_data_out),
        .dest_out        (dest_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bubble();
        wb_en = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        pc = '0; instruction = '0; alu_result = '0; src2_val = '0; dest = '0;
    endtask

    // ready_at: ACCESS cycle (1-based) on which mem_ready is raised; 0 = never.
    task automatic run_op(input string name, input logic wbe, input logic rd, input logic wr,
                          input logic [31:0] alu, input logic [31:0] src2, input logic [4:0] dst,
                          input int ready_at, input logic [31:0] rdata, input logic stray,
                          input logic [31:0] exp_addr, input int exp_req, input int exp_frz);
        exp_t e;
        exp_t got;
        int   req_n = 0;
        int   frz_n = 0;
        bit   done  = 0;
        wb_en = wbe; mem_read = rd; mem_write = wr;
        alu_result = alu; src2_val = src2; dest = dst;
        pc = pc_ctr; instruction = {16'hA5A5, pc_ctr[15:0]};
        e.wb_en = wbe; e.mem_read = rd; e.pc = pc_ctr; e.instr = {16'hA5A5, pc_ctr[15:0]};
        e.alu = alu; e.dest = dst;
        e.data = (rd && ready_at != 0) ? rdata : 32'h0;
        sb.push_back(e);
        pc_ctr = pc_ctr + 32'd4;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clock);
            if (freeze) frz_n++;
            if (mem_req) begin
                req_n++;
                if (req_n == 1) begin
                    check({name, "_addr"}, mem_addr, exp_addr);
                    check({name, "_we"}, {31'b0, mem_we}, {31'b0, wr});
                    if (wr) check({name, "_wdata"}, mem_wdata, src2);
                    check({name, "_wb_hold"}, alu_result_out, prev_alu);
                end
                mem_ready = (req_n == ready_at);
                mem_rdata = (req_n == ready_at) ? rdata : 32'hDEAD_BEEF;
            end else begin
                mem_ready = freeze && stray;
                mem_rdata = 32'hBAD0_BAD0;
            end
            if (!freeze) begin
                @(posedge clock);
                #1;
                done = 1;
            end
        end
        mem_ready = 1'b0;
        bubble();
        if (!done) check({name, "_completion_bound"}, 32'd0, 32'd1);
        check({name, "_req_cycles"}, 32'(req_n), 32'(exp_req));
        check({name, "_freeze_cycles"}, 32'(frz_n), 32'(exp_frz));
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            check({name, "_wb_en_out"}, {31'b0, wb_en_out}, {31'b0, got.wb_en});
            check({name, "_mem_read_out"}, {31'b0, mem_read_out}, {31'b0, got.mem_read});
            check({name, "_pc_out"}, pc_out, got.pc);
            check({name, "_instruction_out"}, instruction_out, got.instr);
            check({name, "_alu_result_out"}, alu_result_out, got.alu);
            check({name, "_mem_data_out"}, mem_data_out, got.data);
            check({name, "_dest_out"}, {27'b0, dest_out}, {27'b0, got.dest});
            prev_alu = got.alu;
        end
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b0; mem_rdata = '0;
        bubble();
        mem_read = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("rst_freeze", {31'b0, freeze}, 32'd0);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_error", {31'b0, mem_error}, 32'd0);
        check("rst_alu_result_out", alu_result_out, 32'd0);
        check("rst_wb_en_out", {31'b0, wb_en_out}, 32'd0);
        bubble();
        @(posedge clock);
        #1 reset = 1'b0;

        run_op("alu", 1'b1, 1'b0, 1'b0, 32'd7, 32'd0, 5'd3, 0, 32'h0, 1'b0, 32'h0, 0, 0);
        run_op("ld_wait2", 1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 5'd5, 2, 32'hCAFE, 1'b0, 32'd2, 2, 3);
        run_op("st_imm", 1'b0, 1'b0, 1'b1, 32'd1028, 32'd5, 5'd0, 1, 32'h5555, 1'b0, 32'd1, 1, 2);
        run_op("ld_edge", 1'b1, 1'b1, 1'b0, 32'd1040, 32'd0, 5'd9, 4, 32'h1234_5678, 1'b0, 32'd4, 4, 5);
        check("edge_no_error", {31'b0, mem_error}, 32'd0);
        run_op("ld_wrap", 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 5'd7, 2, 32'h0BAD_F00D, 1'b1, 32'h3FFF_FF00, 2, 3);
        run_op("ld_tmo", 1'b1, 1'b1, 1'b0, 32'd1101, 32'd0, 5'd11, 0, 32'h0, 1'b0, 32'd19, 4, 5);
        check("tmo_error_set", {31'b0, mem_error}, 32'd1);
        run_op("alu2", 1'b1, 1'b0, 1'b0, 32'h55AA, 32'd0, 5'd12, 0, 32'h0, 1'b0, 32'h0, 0, 0);
        check("error_sticky", {31'b0, mem_error}, 32'd1);

        // Reset arriving while a load is outstanding abandons it.
        wb_en = 1'b1; mem_read = 1'b1; alu_result = 32'd1032; dest = 5'd4; pc = pc_ctr;
        @(negedge clock);
        check("mid_idle_freeze", {31'b0, freeze}, 32'd1);
        @(negedge clock);
        check("mid_access_req", {31'b0, mem_req}, 32'd1);
        reset = 1'b1;
        bubble();
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("mid_rst_req", {31'b0, mem_req}, 32'd0);
        check("mid_rst_freeze", {31'b0, freeze}, 32'd0);
        check("mid_rst_error", {31'b0, mem_error}, 32'd0);
        check("mid_rst_alu_out", alu_result_out, 32'd0);
        check("mid_rst_wb_en_out", {31'b0, wb_en_out}, 32'd0);
        check("mid_rst_data_out", mem_data_out, 32'd0);
        @(negedge clock);
        check("mid_rst_stays_idle", {31'b0, mem_req}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
